// File: rtl/pipeline_hazard_ctrl.sv
// Front-end pipeline control: load-use stalls, taken-branch flushes and data-memory freezes
// for the IF/ID/EX stages, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned BR_PENALTY = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_rd,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             branch_ctr,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned BW = (BR_PENALTY > 0) ? $clog2(BR_PENALTY + 1) : 1;
    localparam logic [BW-1:0] Penalty = BW'(BR_PENALTY);

    typedef enum logic [1:0] {
        StRun,
        StBrFlush,
        StMemWait
    } state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    bubble_q, bubble_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             hazard;
    logic             in_flush;
    logic             accept_br;

    assign hazard = ex_mem_rd && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // MEM_WAIT resumes as BR_FLUSH when bubbles were pending at the time the freeze began.
    assign in_flush = (state_q != StRun) && (bubble_q != '0);

    always_comb begin
        pc_en      = 1'b1;
        branch_ctr = 1'b0;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        accept_br  = 1'b0;
        state_d    = state_q;
        bubble_d   = bubble_q;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = StRun;
            bubble_d   = '0;
        end else if (dmem_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            state_d = StMemWait;
        end else if (branch_taken) begin
            branch_ctr = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            accept_br  = 1'b1;
            bubble_d   = Penalty;
            state_d    = (BR_PENALTY > 0) ? StBrFlush : StRun;
        end else if (in_flush) begin
            ifid_flush = 1'b1;
            bubble_d   = bubble_q - BW'(1);
            state_d    = (bubble_q == BW'(1)) ? StRun : StBrFlush;
        end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = StRun;
        end else begin
            state_d = StRun;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (rst || cnt_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_en && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (accept_br && (flush_q != '1)) begin
                flush_d = flush_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            bubble_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic checked against
// a cycle model built from the control rules (pending-bubble count and integer counters).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned BrPenalty = 1;
    localparam int unsigned CntW      = 4;
    localparam int          CntMax    = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_mem_rd;
    logic            branch_taken, dmem_busy, cnt_clr;
    logic            pc_en, branch_ctr, ifid_en, ifid_flush, idex_en, idex_flush;
    logic [CntW-1:0] stall_cnt, flush_cnt;
    logic [5:0]      outs;

    int checks = 0;
    int errors = 0;

    int m_pend  = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .BR_PENALTY(BrPenalty),
        .CNT_W     (CntW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_rd   (ex_mem_rd),
        .branch_taken(branch_taken),
        .dmem_busy   (dmem_busy),
        .cnt_clr     (cnt_clr),
        .pc_en       (pc_en),
        .branch_ctr  (branch_ctr),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // {pc_en, branch_ctr, ifid_en, ifid_flush, idex_en, idex_flush}
    assign outs = {pc_en, branch_ctr, ifid_en, ifid_flush, idex_en, idex_flush};

    function automatic bit load_use();
        return ex_mem_rd && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [5:0] exp_out();
        if (rst)               return 6'b000101;
        if (dmem_busy)         return 6'b000000;
        if (branch_taken)      return 6'b111111;
        if (m_pend > 0)        return 6'b101110;
        if (load_use())        return 6'b000011;
        return 6'b101010;
    endfunction

    task automatic tick();
        logic [5:0] e;
        e = exp_out();
        if (rst) begin
            m_pend = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (cnt_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e[5] && m_stall < CntMax) m_stall++;
                if (!dmem_busy && branch_taken && m_flush < CntMax) m_flush++;
            end
            if (!dmem_busy) begin
                if (branch_taken) m_pend = BrPenalty;
                else if (m_pend > 0) m_pend--;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_mem_rd = 0; branch_taken = 0; dmem_busy = 0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== 6'b000101) begin
                errors++; $display("FAIL reset_outs cyc%0d got %b want 000101", i, outs);
            end
            checks++;
            if (stall_cnt !== 0 || flush_cnt !== 0) begin
                errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
            end
            tick();
        end
        rst = 0;
        #1;
        checks++;
        if (pc_en !== 1'b1 || outs !== 6'b101010) begin
            errors++; $display("FAIL reset_release got %b want 101010", outs);
        end
        tick();
    endtask

    task automatic test_load_use();
        ex_mem_rd = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 7; id_use_rs1 = 1;
        #1;
        checks++;
        if (outs !== 6'b000011) begin
            errors++; $display("FAIL load_use_stall got %b want 000011", outs);
        end
        tick();
        ex_mem_rd = 0;
        #1;
        checks++;
        if (stall_cnt !== 1 || pc_en !== 1'b1) begin
            errors++; $display("FAIL load_use_cnt got %0d pc_en %b want 1 pc_en 1", stall_cnt, pc_en);
        end
        tick();
        ex_mem_rd = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        #1;
        checks++;
        if (outs !== 6'b101010) begin
            errors++; $display("FAIL load_use_x0 got %b want 101010", outs);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 1) begin
            errors++; $display("FAIL load_use_x0_cnt got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_branch();
        logic [5:0] want [3] = '{6'b111111, 6'b101110, 6'b101010};
        branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== want[i]) begin
                errors++; $display("FAIL branch_cyc%0d got %b want %b", i, outs, want[i]);
            end
            tick();
            branch_taken = 0;
        end
        #1;
        checks++;
        if (flush_cnt !== 1) begin
            errors++; $display("FAIL branch_flush_cnt got %0d want 1", flush_cnt);
        end
    endtask

    task automatic test_mem_busy();
        int base;
        base = int'(stall_cnt);
        dmem_busy = 1; branch_taken = 1;
        ex_mem_rd = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== 6'b000000) begin
                errors++; $display("FAIL mem_busy_cyc%0d got %b want 000000", i, outs);
            end
            tick();
        end
        dmem_busy = 0;
        #1;
        checks++;
        if (outs !== 6'b111111) begin
            errors++; $display("FAIL mem_busy_branch got %b want 111111", outs);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (int'(stall_cnt) !== base + 4 || flush_cnt !== 2) begin
            errors++; $display("FAIL mem_busy_cnt got %0d/%0d want %0d/2", stall_cnt, flush_cnt,
                               base + 4);
        end
        tick();
        tick();
    endtask

    task automatic test_saturate();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        ex_mem_rd = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
        for (int i = 0; i < 18; i++) tick();
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++; $display("FAIL saturate_hold got %0d want 15", stall_cnt);
        end
        tick();
        #1;
        checks++;
        if (stall_cnt !== 4'd15 || pc_en !== 1'b0) begin
            errors++; $display("FAIL saturate_stay got %0d pc_en %b want 15 pc_en 0", stall_cnt, pc_en);
        end
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        #1;
        checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++; $display("FAIL saturate_clr got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_flush();
        branch_taken = 1;
        tick();
        branch_taken = 0; dmem_busy = 1; rst = 1;
        #1;
        checks++;
        if (outs !== 6'b000101) begin
            errors++; $display("FAIL rst_mid_flush got %b want 000101", outs);
        end
        tick();
        rst = 0; dmem_busy = 0;
        #1;
        checks++;
        if (outs !== 6'b101010 || ifid_flush !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flush_release got %b want 101010", outs);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            cnt_clr      = ($urandom_range(0, 39) == 0);
            dmem_busy    = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            ex_mem_rd    = 1'($urandom_range(0, 1));
            ex_rd        = 5'($urandom_range(0, 3));
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (outs !== exp_out()) begin
                errors++; $display("FAIL random_outs cyc%0d got %b want %b", i, outs, exp_out());
            end
            checks++;
            if (int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush) begin
                errors++; $display("FAIL random_cnt cyc%0d got %0d/%0d want %0d/%0d", i, stall_cnt,
                                   flush_cnt, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_saturate();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
